// File: rtl/slatch_arb_pkg.sv
// -----------------------------------------------------------------------------
// slatch_arb_pkg
// Shared types, default sizes and the first-eligible search used by the
// slatch_arb write arbiter.
//
// Contents:
//   NREQ_DEF/DEPTH_DEF/AW_DEF/DW_DEF : default configuration
//   NREQ_MAX                         : widest requester vector the search handles
//   state_e                          : sequencer states (ST_IDLE=0, ST_CLEAR=1)
//   grant_t                          : {valid, idx} result of the search
//   rr_pick()                        : first eligible index from a start point
// -----------------------------------------------------------------------------
package slatch_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 3;
  localparam int DW_DEF    = 16;

  localparam int NREQ_MAX  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } grant_t;

  // Search start, start+1, ... modulo nreq and return the first set bit.
  // Passing start=0 turns this into a plain lowest-index priority pick.
  function automatic grant_t rr_pick(input logic [NREQ_MAX-1:0] elig,
                                     input logic [2:0]          start,
                                     input int                  nreq);
    grant_t g;
    int     j;
    g = '0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      if (k < nreq) begin
        j = int'(start) + k;
        if (j >= nreq) j = j - nreq;
        if (!g.valid && elig[j[2:0]]) begin
          g.valid = 1'b1;
          g.idx   = j[2:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/slatch_arb_ldreg.sv
// -----------------------------------------------------------------------------
// ldreg_sc
// DW-wide register with load enable and synchronous clear. Clear takes
// priority over load. One instance holds one entry of the control bank.
//
// Ports:
//   clk  : rising-edge clock
//   resl : asynchronous active-low reset, forces q to zero
//   ld   : load d on the next edge
//   clr  : clear q on the next edge (wins over ld)
//   d    : load data
//   q    : stored value
// -----------------------------------------------------------------------------
module ldreg_sc #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          resl,
  input  logic          ld,
  input  logic          clr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // NOTE: bank entries are storage but still take the async reset, because the
  // bank must read all-zero immediately after reset (including a reset that
  // interrupts a clear sequence).
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/slatch_arb.sv
// -----------------------------------------------------------------------------
// slatch_arb
// Write arbiter and clear sequencer for a bank of DEPTH load-enable registers.
// NREQ requesters share the single write path through a req/ack handshake;
// a clr_req pulse walks the bank clearing one entry per cycle.
//
// Build option:
//   SLATCH_ARB_FIXED_PRI_EN : when defined, lowest eligible index always wins
//                             and the round-robin pointer is removed.
//
// Ports:
//   clk      : rising-edge clock
//   resl     : asynchronous active-low reset
//   req      : per-requester write request level, held until ack
//   addr     : per-requester target address, requester i at [i*AW +: AW]
//   wdata    : per-requester write data, requester i at [i*DW +: DW]
//   ack      : one-cycle pulse the cycle after the requester's write edge
//   clr_req  : pulse that starts a bank clear
//   clr_busy : high while a clear sequence runs
//   raddr    : read address
//   rdata    : bank[raddr], combinational; zero for raddr >= DEPTH
// -----------------------------------------------------------------------------
module slatch_arb
  import slatch_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic              clk,
  input  logic              resl,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic [AW-1:0]     raddr,
  output logic [DW-1:0]     rdata
);

  state_e          state;
  logic [AW-1:0]   cnt;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] ack_d;
  logic [NREQ-1:0] eligible;
  logic [2:0]      start;
  grant_t          grant;
  logic            wr_en;
  logic [AW-1:0]   addr_g;
  logic [DW-1:0]   wdata_g;
  logic [DW-1:0]   q [DEPTH];

`ifndef SLATCH_ARB_FIXED_PRI_EN
  logic [2:0]      ptr;
  logic [2:0]      ptr_d;
  assign start = ptr;
`else
  assign start = '0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration. A requester whose ack is high this cycle is masked so it
  // cannot be written twice while it is still dropping req.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    eligible = req & ~ack_q;
    grant    = rr_pick(NREQ_MAX'(eligible), start, NREQ);
    // clr_req beats a simultaneous request; that request stays pending.
    wr_en    = (state == ST_IDLE) && !clr_req && grant.valid;
    addr_g   = addr[int'(grant.idx)*AW +: AW];
    wdata_g  = wdata[int'(grant.idx)*DW +: DW];
    ack_d    = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack_d[i] = wr_en && (grant.idx == 3'(i));
    end
  end

`ifndef SLATCH_ARB_FIXED_PRI_EN
  always_comb begin
    ptr_d = ptr;
    if (wr_en) begin
      ptr_d = (int'(grant.idx) == NREQ - 1) ? 3'd0 : grant.idx + 3'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE arbitrates writes, CLEAR walks the bank for DEPTH cycles.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ack_q <= '0;
`ifndef SLATCH_ARB_FIXED_PRI_EN
      ptr   <= '0;
`endif
    end else begin
      ack_q <= ack_d;
`ifndef SLATCH_ARB_FIXED_PRI_EN
      ptr   <= ptr_d;
`endif
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          // clr_req is ignored here; the walk always runs to completion.
          if (cnt == AW'(DEPTH - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign clr_busy = (state == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Register bank. An address >= DEPTH matches no entry, so such a request is
  // acked without changing the bank.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_bank
    logic ld;
    logic clr;
    assign ld  = wr_en && (addr_g == AW'(i));
    assign clr = (state == ST_CLEAR) && (cnt == AW'(i));

    ldreg_sc #(.DW(DW)) u_reg (
      .clk  (clk),
      .resl (resl),
      .ld   (ld),
      .clr  (clr),
      .d    (wdata_g),
      .q    (q[i])
    );
  end

  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) begin
      rdata = q[raddr];
    end
  end

endmodule

// File: tb/tb_slatch_arb.sv
// -----------------------------------------------------------------------------
// tb_slatch_arb
// Directed self-checking bench for slatch_arb (NREQ=4, DEPTH=8, AW=3, DW=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Expectations follow the round-robin build unless SLATCH_ARB_FIXED_PRI_EN is
// defined, in which case the fixed-priority expectations apply.
// -----------------------------------------------------------------------------
module tb_slatch_arb;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 16;

  logic               clk = 1'b0;
  logic               resl;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ack;
  logic               clr_req;
  logic               clr_busy;
  logic [AW-1:0]      raddr;
  logic [DW-1:0]      rdata;

  int errors = 0;
  int checks = 0;

  slatch_arb #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .resl     (resl),
    .req      (req),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .raddr    (raddr),
    .rdata    (rdata)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input int a, input logic [DW-1:0] exp);
    raddr = AW'(a);
    #1;
    chk(tag, 32'(rdata), 32'(exp));
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]             = 1'b1;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  // Single write from requester i; leaves the bench one cycle after the ack.
  task automatic write_one(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [NREQ-1:0] e;
    e    = '0;
    e[i] = 1'b1;
    set_req(i, a, d);
    tick();
    chk("wr_ack", 32'(ack), 32'(e));
    req[i] = 1'b0;
    tick();
  endtask

  logic [NREQ-1:0] grant_seq [5];
  logic [NREQ-1:0] coll_first;
  logic [NREQ-1:0] coll_second;
  logic [DW-1:0]   coll_val1;
  logic [DW-1:0]   coll_final;
  logic [DW-1:0]   rr_e2;
  logic [DW-1:0]   rr_e3;

  initial begin
`ifdef SLATCH_ARB_FIXED_PRI_EN
    grant_seq   = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    rr_e2       = 16'h0000;
    rr_e3       = 16'h0000;
    coll_first  = 4'b0001;
    coll_second = 4'b0010;
    coll_val1   = 16'h1111;
    coll_final  = 16'h2222;
`else
    grant_seq   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_e2       = 16'h1002;
    rr_e3       = 16'h1003;
    coll_first  = 4'b0010;
    coll_second = 4'b0001;
    coll_val1   = 16'h2222;
    coll_final  = 16'h1111;
`endif

    resl    = 1'b0;
    req     = '0;
    addr    = '0;
    wdata   = '0;
    clr_req = 1'b0;
    raddr   = '0;

    // Reset state
    #3;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(clr_busy), 32'h0);
    for (int a = 0; a < DEPTH; a++) peek("rst_rdata", a, 16'h0000);
    tick();
    tick();
    resl = 1'b1;
    tick();

    // Single write; the ack mask blocks a second write while req is still high
    set_req(2, 3'd5, 16'hA5A5);
    tick();
    chk("w2_ack", 32'(ack), 32'h4);
    peek("w2_rdata", 5, 16'hA5A5);
    tick();
    chk("w2_mask", 32'(ack), 32'h0);
    req[2] = 1'b0;
    tick();
    chk("w2_idle", 32'(ack), 32'h0);
    peek("w2_keep", 5, 16'hA5A5);

    // Reset so the round-robin pointer starts at 0
    resl = 1'b0;
    #2;
    resl = 1'b1;
    tick();

    // All four requesters held high to addresses 0..3
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), DW'(16'h1000 + i));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("arb_ack", 32'(ack), 32'(grant_seq[k]));
    end
    req = '0;
    tick();
    chk("arb_drain", 32'(ack), 32'h0);
    peek("arb_e0", 0, 16'h1000);
    peek("arb_e1", 1, 16'h1001);
    peek("arb_e2", 2, rr_e2);
    peek("arb_e3", 3, rr_e3);

    // Fill the bank, then clear with a simultaneous req[1]
    for (int a = 0; a < DEPTH; a++) write_one(0, AW'(a), 16'hFFFF);
    clr_req = 1'b1;
    set_req(1, 3'd2, 16'h1234);
    tick();
    clr_req = 1'b0;
    chk("clr_nogrant", 32'(ack), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_busy", 32'(clr_busy), 32'h1);
      chk("clr_ack", 32'(ack), 32'h0);
      if (i == 2) begin
        peek("clr_part0", 1, 16'h0000);
        peek("clr_part1", 2, 16'hFFFF);
      end
      if (i == 4) clr_req = 1'b1;
      if (i == 5) clr_req = 1'b0;
      tick();
    end
    chk("clr_done", 32'(clr_busy), 32'h0);
    chk("clr_done_ack", 32'(ack), 32'h0);
    for (int a = 0; a < DEPTH; a++) peek("clr_zero", a, 16'h0000);
    tick();
    chk("clr_pend_ack", 32'(ack), 32'h2);
    peek("clr_pend_data", 2, 16'h1234);
    req[1] = 1'b0;
    tick();
    chk("clr_pend_end", 32'(ack), 32'h0);

    // Reset while the clear counter is 3
    for (int a = 4; a < DEPTH; a++) write_one(0, AW'(a), 16'hFFFF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    tick();
    chk("rc_busy", 32'(clr_busy), 32'h1);
    peek("rc_pre", 4, 16'hFFFF);
    resl = 1'b0;
    #1;
    chk("rc_busy_rst", 32'(clr_busy), 32'h0);
    chk("rc_ack_rst", 32'(ack), 32'h0);
    for (int a = 4; a < DEPTH; a++) peek("rc_zero", a, 16'h0000);
    resl = 1'b1;
    tick();
    chk("rc_idle", 32'(clr_busy), 32'h0);

    // Read-after-write in the ack cycle
    set_req(0, 3'd7, 16'hBEEF);
    tick();
    chk("raw_ack", 32'(ack), 32'h1);
    peek("raw_data", 7, 16'hBEEF);
    req[0] = 1'b0;
    tick();

    // Two requesters to the same address: sequential writes, last one stays
    set_req(0, 3'd4, 16'h1111);
    set_req(1, 3'd4, 16'h2222);
    tick();
    chk("col_ack1", 32'(ack), 32'(coll_first));
    peek("col_data1", 4, coll_val1);
    req = req & ~coll_first;
    tick();
    chk("col_ack2", 32'(ack), 32'(coll_second));
    req = '0;
    peek("col_final", 4, coll_final);
    tick();
    chk("col_end", 32'(ack), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
